// File: rtl/misao_mem_bridge_if.sv
// Core-side and external-memory-side signals of the memory bridge.
// The slave modport is the bridge's view; master is the core/memory environment.
interface misao_mem_bridge_if #(
    parameter int ADDR_W = 15
);
    logic              core_rd_en;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_addr;
    logic [7:0]        core_wdata;
    logic [7:0]        core_rdata;
    logic              core_stall;
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [7:0]        ext_wdata;
    logic              ext_ack;
    logic [7:0]        ext_rdata;
    logic              bus_err;

    modport slave (
        input  core_rd_en, core_wr_en, core_addr, core_wdata, ext_ack, ext_rdata,
        output core_rdata, core_stall, ext_req, ext_we, ext_addr, ext_wdata, bus_err
    );

    modport master (
        output core_rd_en, core_wr_en, core_addr, core_wdata, ext_ack, ext_rdata,
        input  core_rdata, core_stall, ext_req, ext_we, ext_addr, ext_wdata, bus_err
    );
endinterface

// File: rtl/misao_mem_bridge.sv
// Byte-wide core-to-external-memory bridge with a one-entry read buffer,
// stall-based handshake and a sticky timeout error.
module misao_mem_bridge #(
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    misao_mem_bridge_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              err_q, err_d;
    logic [7:0]        rdata;
    logic              stall;
    logic              hit;
    logic              timeout;

    assign hit = bus.core_rd_en && !bus.core_wr_en && buf_valid_q &&
                 (buf_addr_q == bus.core_addr);
    // A same-cycle ack beats the timeout.
    assign timeout = (cnt_q == 8'(TIMEOUT)) && !bus.ext_ack;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        we_d        = we_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        err_d       = err_q;
        rdata       = buf_data_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.core_wr_en) begin
                    stall   = 1'b1;
                    addr_d  = bus.core_addr;
                    wdata_d = bus.core_wdata;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = WR_REQ;
                end else if (bus.core_rd_en && !hit) begin
                    stall   = 1'b1;
                    addr_d  = bus.core_addr;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = RD_REQ;
                end
            end
            RD_REQ, WR_REQ: begin
                stall = 1'b1;
                if (bus.ext_ack) begin
                    stall   = 1'b0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                    if (state_q == RD_REQ) begin
                        rdata       = bus.ext_rdata;
                        buf_valid_d = 1'b1;
                        buf_addr_d  = addr_q;
                        buf_data_d  = bus.ext_rdata;
                    end else if (buf_valid_q && (buf_addr_q == addr_q)) begin
                        buf_data_d = wdata_q;
                    end
                end else if (timeout) begin
                    stall       = 1'b0;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    state_d     = IDLE;
                    err_d       = 1'b1;
                    buf_valid_d = 1'b0;
                    if (state_q == RD_REQ) rdata = 8'hFF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
            rdata = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= '0;
            wdata_q     <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            we_q        <= we_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.core_rdata = rdata;
    assign bus.core_stall = stall;
    assign bus.ext_req    = req_q;
    assign bus.ext_we     = we_q;
    assign bus.ext_addr   = addr_q;
    assign bus.ext_wdata  = wdata_q;
    assign bus.bus_err    = err_q;
endmodule

// File: tb/tb_misao_mem_bridge.sv
// Directed bench: per-cycle vector table for the main flows, then
// hand-written sequences for timeout, sticky error and ack/timeout tie.
module tb_misao_mem_bridge;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    misao_mem_bridge_if #(.ADDR_W(AW)) bus ();
    misao_mem_bridge #(.ADDR_W(AW), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          r, rd, wr;
        logic [AW-1:0] a;
        logic [7:0]    wd;
        logic          ack;
        logic [7:0]    ard;
        logic          st;
        logic [7:0]    rdat;
        logic          req, we, err;
        logic [AW-1:0] ea;
        logic [7:0]    ewd;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic r, logic rd, logic wr, logic [AW-1:0] a, logic [7:0] wd,
                                logic ack, logic [7:0] ard, logic st, logic [7:0] rdat,
                                logic req, logic we, logic err, logic [AW-1:0] ea, logic [7:0] ewd);
        vec_t v;
        v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.ard = ard;
        v.st = st; v.rdat = rdat; v.req = req; v.we = we; v.err = err; v.ea = ea; v.ewd = ewd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [7:0] wd, input logic ack, input logic [7:0] ard);
        rst = r;
        bus.core_rd_en = rd;
        bus.core_wr_en = wr;
        bus.core_addr  = a;
        bus.core_wdata = wd;
        bus.ext_ack    = ack;
        bus.ext_rdata  = ard;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int   nst;
    logic ok;

    initial begin
        //         r  rd wr addr     wd     ack ard    | st rdat   req we err ea       ewd
        vq.push_back(mk(1, 0, 0, 15'h000, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 15'h000, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0, 15'h000, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 1, 8'h45, 0, 8'h45, 1, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 0, 8'h45, 0, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 0, 0, 15'h000, 8'h00, 1, 8'h77, 0, 8'h45, 0, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 0, 1, 15'h003, 8'hA5, 0, 8'h00, 1, 8'h45, 0, 0, 0, 15'h003, 8'h00));
        vq.push_back(mk(0, 0, 1, 15'h003, 8'hA5, 0, 8'h00, 1, 8'h45, 1, 1, 0, 15'h003, 8'hA5));
        vq.push_back(mk(0, 0, 1, 15'h003, 8'hA5, 1, 8'h00, 0, 8'h45, 1, 1, 0, 15'h003, 8'hA5));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 0, 8'hA5, 0, 0, 0, 15'h003, 8'hA5));
        vq.push_back(mk(0, 1, 1, 15'h010, 8'h3C, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 15'h003, 8'hA5));
        vq.push_back(mk(0, 1, 1, 15'h010, 8'h3C, 1, 8'h00, 0, 8'hA5, 1, 1, 0, 15'h010, 8'h3C));
        vq.push_back(mk(0, 1, 0, 15'h010, 8'h00, 0, 8'h00, 1, 8'hA5, 0, 0, 0, 15'h010, 8'h3C));
        vq.push_back(mk(0, 1, 0, 15'h010, 8'h00, 1, 8'h5A, 0, 8'h5A, 1, 0, 0, 15'h010, 8'h3C));
        vq.push_back(mk(0, 1, 0, 15'h003, 8'h00, 0, 8'h00, 1, 8'h5A, 0, 0, 0, 15'h010, 8'h3C));
        vq.push_back(mk(1, 1, 0, 15'h003, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 0, 15'h003, 8'h3C));
        vq.push_back(mk(0, 0, 0, 15'h000, 8'h00, 1, 8'h99, 0, 8'h00, 0, 0, 0, 15'h000, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h010, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 0, 15'h000, 8'h00));
        vq.push_back(mk(0, 1, 0, 15'h010, 8'h00, 1, 8'h11, 0, 8'h11, 1, 0, 0, 15'h010, 8'h00));
        vq.push_back(mk(0, 0, 0, 15'h000, 8'h00, 0, 8'h00, 0, 8'h11, 0, 0, 0, 15'h010, 8'h00));

        apply(1, 0, 0, '0, 8'h00, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].r, vq[i].rd, vq[i].wr, vq[i].a, vq[i].wd, vq[i].ack, vq[i].ard);
            #4;
            check("stall", i, 32'(bus.core_stall), 32'(vq[i].st));
            check("rdata", i, 32'(bus.core_rdata), 32'(vq[i].rdat));
            check("ext_req", i, 32'(bus.ext_req), 32'(vq[i].req));
            check("ext_we", i, 32'(bus.ext_we), 32'(vq[i].we));
            check("bus_err", i, 32'(bus.bus_err), 32'(vq[i].err));
            check("ext_addr", i, 32'(bus.ext_addr), 32'(vq[i].ea));
            check("ext_wdata", i, 32'(bus.ext_wdata), 32'(vq[i].ewd));
            tick();
        end

        // Timeout on a read at the top address: 17 stall cycles, then 0xFF.
        apply(0, 1, 0, 15'h7FFF, 8'h00, 0, 8'h00);
        nst = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (bus.core_stall !== 1'b1) begin
                ok = 1'b1;
                break;
            end
            nst++;
            tick();
        end
        check("to_bound", 0, 32'(ok), 32'd1);
        check("to_stalls", 0, 32'(nst), 32'd17);
        check("to_rdata", 0, 32'(bus.core_rdata), 32'hFF);
        check("to_req_last", 0, 32'(bus.ext_req), 32'd1);
        check("to_err_pre", 0, 32'(bus.bus_err), 32'd0);
        tick();
        apply(0, 0, 0, '0, 8'h00, 0, 8'h00);
        #4;
        check("to_req_drop", 0, 32'(bus.ext_req), 32'd0);
        check("to_err_set", 0, 32'(bus.bus_err), 32'd1);
        check("to_rdata_buf", 0, 32'(bus.core_rdata), 32'h11);
        tick();

        // Buffer was invalidated, so 0x010 misses; error stays sticky.
        apply(0, 1, 0, 15'h010, 8'h00, 0, 8'h00);
        #4;
        check("inval_miss", 0, 32'(bus.core_stall), 32'd1);
        tick();
        apply(0, 1, 0, 15'h010, 8'h00, 1, 8'h22);
        #4;
        check("inval_fwd", 0, 32'(bus.core_rdata), 32'h22);
        check("sticky_err", 0, 32'(bus.bus_err), 32'd1);
        tick();
        apply(0, 0, 0, '0, 8'h00, 0, 8'h00);
        #4;
        check("sticky_err", 1, 32'(bus.bus_err), 32'd1);
        tick();
        apply(1, 0, 0, '0, 8'h00, 0, 8'h00);
        tick();
        apply(0, 0, 0, '0, 8'h00, 0, 8'h00);
        #4;
        check("err_clear", 0, 32'(bus.bus_err), 32'd0);
        tick();

        // Ack arriving in the same cycle the counter hits TIMEOUT wins.
        apply(0, 1, 0, 15'h020, 8'h00, 0, 8'h00);
        tick();
        for (int i = 0; i < 16; i++) begin
            #4;
            check("tie_stall", i, 32'(bus.core_stall), 32'd1);
            tick();
        end
        apply(0, 1, 0, 15'h020, 8'h00, 1, 8'h66);
        #4;
        check("tie_stall_rel", 0, 32'(bus.core_stall), 32'd0);
        check("tie_rdata", 0, 32'(bus.core_rdata), 32'h66);
        tick();
        apply(0, 1, 0, 15'h020, 8'h00, 0, 8'h00);
        #4;
        check("tie_no_err", 0, 32'(bus.bus_err), 32'd0);
        check("tie_hit", 0, 32'(bus.core_stall), 32'd0);
        check("tie_hit_data", 0, 32'(bus.core_rdata), 32'h66);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
